// File: rtl/scan_pkg.sv
// Shared definitions for the scan address sequencer: FSM state encoding and
// direction codes used by the top and the bench.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/scan_addr_gen_if.sv
// Control/status bundle between a scan controller (master) and the
// scan_addr_gen sequencer (slave).
interface scan_addr_gen_if #(
    parameter int ADDR_W  = 4,
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               pause;
    logic               dir;
    logic               loop;
    logic [ADDR_W-1:0]  first_addr;
    logic [ADDR_W-1:0]  last_addr;
    logic [DWELL_W-1:0] dwell;
    logic [ADDR_W-1:0]  addr;
    logic               addr_valid;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, stop, pause, dir, loop, first_addr, last_addr, dwell,
        input  addr, addr_valid, busy, done, wrap
    );

    modport slave (
        input  start, stop, pause, dir, loop, first_addr, last_addr, dwell,
        output addr, addr_valid, busy, done, wrap
    );
endinterface

// File: rtl/scan_addr_gen_dwell_timer.sv
// Dwell counter: counts enabled cycles, flags when the count reaches limit.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] limit,
    output logic               expire
);
    logic [DWELL_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + DWELL_W'(1);
    end

    assign expire = (count == limit);
endmodule

// File: rtl/scan_addr_gen.sv
// Programmable 4-bit address sequencer feeding the downstream 4-to-16 decoder;
// steps [first..last] up or down with per-address dwell, loop, pause and abort.
module scan_addr_gen
    import scan_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DWELL_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    scan_addr_gen_if.slave  bus
);
    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic               valid_q, busy_q, done_q, wrap_q;

    logic               cfg_dir, cfg_loop;
    logic [ADDR_W-1:0]  cfg_first, cfg_last;
    logic [DWELL_W-1:0] cfg_dwell;

    logic               start_ok, run_ok, tmr_clr, tmr_en, tmr_expire;
    logic [ADDR_W-1:0]  addr_step;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        start_ok  = 1'b0;
        run_ok    = 1'b0;
        start_ok  = (state == ST_IDLE) && bus.start && !bus.stop;
        // HOLD with pause released behaves like RUN for that cycle.
        run_ok    = (state != ST_IDLE) && !bus.stop && !bus.pause;
        tmr_clr   = start_ok || (run_ok && tmr_expire);
        tmr_en    = run_ok && !tmr_expire;
        addr_step = (cfg_dir == DIR_UP) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
    end

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .limit  (cfg_dwell),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cfg_dir   <= 1'b0;
            cfg_loop  <= 1'b0;
            cfg_first <= '0;
            cfg_last  <= '0;
            cfg_dwell <= '0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_RUN;
                        addr_q    <= bus.first_addr;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        cfg_dir   <= bus.dir;
                        cfg_loop  <= bus.loop;
                        cfg_first <= bus.first_addr;
                        cfg_last  <= bus.last_addr;
                        cfg_dwell <= bus.dwell;
                    end
                end
                default: begin
                    if (bus.stop) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (bus.pause) begin
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_RUN;
                        if (tmr_expire) begin
                            if (addr_q != cfg_last) begin
                                addr_q <= addr_step;
                            end else if (cfg_loop) begin
                                addr_q <= cfg_first;
                                wrap_q <= 1'b1;
                            end else begin
                                state   <= ST_IDLE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.addr       = addr_q;
    assign bus.addr_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_scan_addr_gen.sv
// Self-checking bench for scan_addr_gen: vector table, directed corner cases
// and random stimulus against an index-based scan model.
module tb_scan_addr_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scan_addr_gen_if #(.ADDR_W(4), .DWELL_W(8)) bus ();

    scan_addr_gen #(.ADDR_W(4), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a scan is position k of 'steps' positions, each held dwell+1 runnable cycles.
    bit         m_active, m_done, m_wrap, m_dir, m_loop;
    logic [3:0] m_addr, m_first, m_last;
    int         m_dwell, m_steps, m_k, m_t;

    task automatic model_reset();
        m_active = 0; m_done = 0; m_wrap = 0; m_addr = 4'd0;
        m_k = 0; m_t = 0;
    endtask

    task automatic model_step();
        logic [3:0] span;
        m_done = 0;
        m_wrap = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_active) begin
            if (bus.start && !bus.stop) begin
                m_dir = bus.dir; m_loop = bus.loop;
                m_first = bus.first_addr; m_last = bus.last_addr;
                m_dwell = int'(bus.dwell);
                span = m_dir ? m_first - m_last : m_last - m_first;
                m_steps = int'(span) + 1;
                m_k = 0; m_t = 0; m_active = 1;
            end
        end else if (bus.stop) begin
            m_active = 0;
        end else if (!bus.pause) begin
            if (m_t == m_dwell) begin
                m_t = 0;
                if (m_k == m_steps - 1) begin
                    if (m_loop) begin m_k = 0; m_wrap = 1; end
                    else begin m_active = 0; m_done = 1; end
                end else begin
                    m_k++;
                end
            end else begin
                m_t++;
            end
        end
        if (m_active)
            m_addr = m_dir ? m_first - 4'(m_k) : m_first + 4'(m_k);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_addr",  {28'd0, bus.addr}, {28'd0, m_addr});
        check("model_valid", {31'd0, bus.addr_valid}, {31'd0, m_active});
        check("model_busy",  {31'd0, bus.busy}, {31'd0, m_active});
        check("model_done",  {31'd0, bus.done}, {31'd0, m_done});
        check("model_wrap",  {31'd0, bus.wrap}, {31'd0, m_wrap});
    endtask

    task automatic drive(input bit st, input bit sp, input bit pa, input bit d,
                         input bit lp, input int f, input int l, input int dw);
        bus.start = st; bus.stop = sp; bus.pause = pa; bus.dir = d; bus.loop = lp;
        bus.first_addr = 4'(f); bus.last_addr = 4'(l); bus.dwell = 8'(dw);
    endtask

    typedef struct {
        bit start, stop, pause, dir, loop;
        int first, last, dwell;
        int e_addr;
        bit e_valid, e_done, e_wrap;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // single-shot up 2..5, dwell 0
        tbl.push_back('{1,0,0,0,0, 2,5,0, 2,1,0,0});
        tbl.push_back('{0,0,0,0,0, 2,5,0, 3,1,0,0});
        tbl.push_back('{0,0,0,0,0, 2,5,0, 4,1,0,0});
        tbl.push_back('{0,0,0,0,0, 2,5,0, 5,1,0,0});
        tbl.push_back('{0,0,0,0,0, 2,5,0, 5,0,1,0});
        tbl.push_back('{0,0,0,0,0, 2,5,0, 5,0,0,0});
        // loop down 3..1, dwell 0, then abort
        tbl.push_back('{1,0,0,1,1, 3,1,0, 3,1,0,0});
        tbl.push_back('{0,0,0,1,1, 3,1,0, 2,1,0,0});
        tbl.push_back('{0,0,0,1,1, 3,1,0, 1,1,0,0});
        tbl.push_back('{0,0,0,1,1, 3,1,0, 3,1,0,1});
        tbl.push_back('{0,0,0,1,1, 3,1,0, 2,1,0,0});
        tbl.push_back('{0,0,0,1,1, 3,1,0, 1,1,0,0});
        tbl.push_back('{0,0,0,1,1, 3,1,0, 3,1,0,1});
        tbl.push_back('{0,1,0,1,1, 3,1,0, 3,0,0,0});

        rst_n = 1'b0;
        drive(0,0,0,0,0, 0,0,0);
        model_reset();
        repeat (2) tick();
        check("reset_addr", {28'd0, bus.addr}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].dir, tbl[i].loop,
                  tbl[i].first, tbl[i].last, tbl[i].dwell);
            tick();
            check($sformatf("tbl%0d_addr", i), {28'd0, bus.addr}, 32'(tbl[i].e_addr));
            check($sformatf("tbl%0d_valid", i), {31'd0, bus.addr_valid}, {31'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d_done", i), {31'd0, bus.done}, {31'd0, tbl[i].e_done});
            check($sformatf("tbl%0d_wrap", i), {31'd0, bus.wrap}, {31'd0, tbl[i].e_wrap});
        end

        // wrap-around up 14..1, dwell 2: 12 valid cycles then done
        drive(1,0,0,0,0, 14,1,2);
        tick();
        drive(0,0,0,0,0, 14,1,2);
        for (int i = 0; i < 12; i++) begin
            check("wrap_up_addr", {28'd0, bus.addr}, 32'((14 + i / 3) % 16));
            check("wrap_up_valid", {31'd0, bus.addr_valid}, 32'd1);
            tick();
        end
        check("wrap_up_done", {31'd0, bus.done}, 32'd1);
        tick();
        check("wrap_up_done_once", {31'd0, bus.done}, 32'd0);

        // pause: 6..9 up, dwell 3; pause 5 cycles from 2nd cycle of addr 7
        drive(1,0,0,0,0, 6,9,3);
        tick();
        drive(0,0,0,0,0, 6,9,3);
        repeat (4) tick();
        check("pause_addr7_c0", {28'd0, bus.addr}, 32'd7);
        tick();
        bus.pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pause_hold_addr", {28'd0, bus.addr}, 32'd7);
            check("pause_hold_valid", {31'd0, bus.addr_valid}, 32'd1);
        end
        bus.pause = 1'b0;
        repeat (2) tick();
        check("pause_resume_addr7", {28'd0, bus.addr}, 32'd7);
        tick();
        check("pause_advance_addr8", {28'd0, bus.addr}, 32'd8);
        repeat (4) tick();
        check("stop_pre_addr9", {28'd0, bus.addr}, 32'd9);
        bus.stop = 1'b1;
        tick();
        check("stop_addr", {28'd0, bus.addr}, 32'd9);
        check("stop_valid", {31'd0, bus.addr_valid}, 32'd0);
        check("stop_busy", {31'd0, bus.busy}, 32'd0);
        check("stop_done", {31'd0, bus.done}, 32'd0);

        // start with stop in IDLE
        drive(1,1,0,0,0, 0,3,0);
        tick();
        check("start_stop_busy", {31'd0, bus.busy}, 32'd0);

        // start while busy must not re-latch
        drive(1,0,0,0,0, 0,3,0);
        tick();
        drive(1,0,0,1,1, 10,12,5);
        tick();
        check("restart_ign_1", {28'd0, bus.addr}, 32'd1);
        drive(0,0,0,1,1, 10,12,5);
        tick();
        tick();
        check("restart_ign_3", {28'd0, bus.addr}, 32'd3);
        tick();
        check("restart_ign_done", {31'd0, bus.done}, 32'd1);

        // asynchronous reset mid-scan
        drive(1,0,0,0,1, 4,12,1);
        tick();
        drive(0,0,0,0,1, 4,12,1);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("areset_addr", {28'd0, bus.addr}, 32'd0);
        check("areset_valid", {31'd0, bus.addr_valid}, 32'd0);
        check("areset_busy", {31'd0, bus.busy}, 32'd0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_valid", {31'd0, bus.addr_valid}, 32'd0);

        // random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start      = ($urandom_range(0, 5) == 0);
            bus.stop       = ($urandom_range(0, 40) == 0);
            bus.pause      = ($urandom_range(0, 6) == 0);
            bus.dir        = 1'($urandom);
            bus.loop       = ($urandom_range(0, 3) == 0);
            bus.first_addr = 4'($urandom);
            bus.last_addr  = 4'($urandom);
            bus.dwell      = 8'($urandom_range(0, 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
